// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its decode-side buffer.
package instruction_fetch_unit_pkg;

    localparam int unsigned ADDR_WIDTH   = 32;
    localparam int unsigned INSTR_WIDTH  = 32;
    localparam int unsigned PC_INCREMENT = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instruction;
    } fetch_entry_t;

    // Instructions are word aligned; the low two address bits are always zero.
    function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Cache request/response, branch redirect and decode handshake signals of the fetch unit.
interface instruction_fetch_unit_if;
    import instruction_fetch_unit_pkg::*;

    logic                   branch_taken;
    logic [ADDR_WIDTH-1:0]  branch_target;
    logic [ADDR_WIDTH-1:0]  pc;
    logic                   pc_valid;
    logic                   stall_instruction_cache;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   instruction_cache_ready;
    logic [ADDR_WIDTH-1:0]  if_pc;
    logic [INSTR_WIDTH-1:0] if_instruction;
    logic                   if_valid;
    logic                   id_ready;

    modport master (
        input  branch_taken, branch_target, instruction, instruction_cache_ready, id_ready,
        output pc, pc_valid, stall_instruction_cache, if_pc, if_instruction, if_valid
    );

    modport slave (
        output branch_taken, branch_target, instruction, instruction_cache_ready, id_ready,
        input  pc, pc_valid, stall_instruction_cache, if_pc, if_instruction, if_valid
    );

endinterface

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Synchronous FIFO holding fetched {pc, instruction} entries toward decode; flush empties it in one edge.
module instruction_fetch_unit_fetch_buffer
    import instruction_fetch_unit_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wr_entry,
    output fetch_entry_t     rd_entry,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next_c;
    logic             do_push;
    logic             do_pop;

    // Flush wins over both push and pop.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        count_next_c = count;
        if (flush) begin
            count_next_c = '0;
        end else if (do_push && !do_pop) begin
            count_next_c = count + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_next_c = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            count <= count_next_c;
            full  <= (count_next_c == CNT_W'(DEPTH));
            empty <= (count_next_c == '0);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Storage is reset so the head outputs read zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch initiator: drives cache requests, buffers responses toward decode and handles branch redirects.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned           BUFFER_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instruction_fetch_unit_if.master  bus
);

    localparam int unsigned CNT_W = $clog2(BUFFER_DEPTH + 1);

    fetch_state_e          state_q;
    fetch_state_e          state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [ADDR_WIDTH-1:0] target_q;
    logic [ADDR_WIDTH-1:0] target_d;
    logic [ADDR_WIDTH-1:0] branch_pc;
    logic                  pc_valid_q;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    fetch_entry_t          wr_entry;
    fetch_entry_t          rd_entry;

    assign branch_pc = align_pc(bus.branch_target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= align_pc(RESET_VECTOR);
            target_q   <= '0;
            pc_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            pc_valid_q <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        target_d = target_q;
        push     = 1'b0;
        flush    = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (bus.branch_taken) begin
                    flush = 1'b1;
                    pc_d  = branch_pc;
                end
            end
            FETCH: begin
                if (bus.branch_taken) begin
                    flush = 1'b1;
                    // A response arriving with the redirect is dropped; a pending miss must be drained first.
                    if (bus.instruction_cache_ready) begin
                        pc_d = branch_pc;
                    end else begin
                        target_d = branch_pc;
                        state_d  = DISCARD;
                    end
                end else if (bus.instruction_cache_ready && (count != CNT_W'(BUFFER_DEPTH))) begin
                    push = 1'b1;
                    pc_d = pc_q + ADDR_WIDTH'(PC_INCREMENT);
                end
            end
            DISCARD: begin
                if (bus.branch_taken) begin
                    flush    = 1'b1;
                    target_d = branch_pc;
                end
                if (bus.instruction_cache_ready) begin
                    pc_d    = bus.branch_taken ? branch_pc : target_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pop      = !empty && bus.id_ready;
    assign wr_entry = '{pc: pc_q, instruction: bus.instruction};

    instruction_fetch_unit_fetch_buffer #(
        .DEPTH (BUFFER_DEPTH)
    ) u_fetch_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (flush),
        .wr_entry (wr_entry),
        .rd_entry (rd_entry),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    // The buffer is only ever non-empty in FETCH (flushed on entry to DISCARD), so full is the stall.
    assign bus.pc                      = pc_q;
    assign bus.pc_valid                = pc_valid_q;
    assign bus.stall_instruction_cache = full;
    assign bus.if_pc                   = rd_entry.pc;
    assign bus.if_instruction          = rd_entry.instruction;
    assign bus.if_valid                = !empty;

endmodule
